mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
Bus initiator for the 32-bit-data / 16-bit-address single-port memory (Mem_D32b_A16b: data_out, data_in, address, write, clk). On a start request it copies a block of N words from a source address to a destination address by driving the memory's address/data_in/write pins and sampling data_out. It reports completion and an XOR checksum of the copied words. It sits between a host/test controller and the memory and is the only driver of the memory pins while busy.

Parameters:
AW, 16, memory address width (matches memory)
DW, 32, memory data width (matches memory)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  copy request, sampled only in IDLE
src_addr  in  AW  first source word address, latched on accepted start
dst_addr  in  AW  first destination word address, latched on accepted start
length  in  AW  number of words to copy, latched on accepted start
busy  out  1  high from the cycle after an accepted start until DONE is left
done  out  1  one-cycle pulse at end of transfer
checksum  out  DW  XOR of all words copied in the last transfer; held until next start
mem_addr  out  AW  to memory address
mem_wdata  out  DW  to memory data_in
mem_write  out  1  to memory write
mem_rdata  in  DW  from memory data_out

Behaviour:
- All outputs registered. Reset (rst_n=0, any time, asynchronous): state IDLE; busy=0, done=0, mem_write=0, mem_addr=0, mem_wdata=0, checksum=0, internal counters 0. Reset mid-transfer aborts immediately, mem_write drops without waiting for clk, and no partial done is produced.
- States: IDLE, RD, RDW, WR, FIN.
- IDLE: busy=0, mem_write=0. start=1 at an edge -> latch src/dst/length, clear checksum, remaining=length. If length==0 -> FIN, else -> RD.
- RD: mem_addr=src_ptr, mem_write=0. -> RDW.
- RDW: mem_addr held at src_ptr; at the end of this cycle mem_rdata is captured into a data register (one cycle after the address is presented; address held stable so combinational and registered-read memories are both served). -> WR.
- WR: mem_addr=dst_ptr, mem_wdata=captured word, mem_write=1 for exactly this one cycle; the memory commits on the closing edge. checksum ^= word; src_ptr++, dst_ptr++, remaining--. If remaining becomes 0 -> FIN, else -> RD.
- FIN: done=1 for one cycle, busy=1, mem_write=0. -> IDLE.
- Throughput: 3 cycles per word. Total from accepting start to done pulse: 3*N+1 cycles (N=0: 1 cycle).
- Address arithmetic modulo 2^AW: pointers at 16'hFFFF wrap to 16'h0000, no error.
- start while not IDLE is ignored; it is not queued. start held high in FIN is accepted on the IDLE cycle that follows.
- Overlapping ranges: strict forward word-by-word copy. If dst lies within (src, src+N), overwritten source words are re-read; this is defined behaviour, not an error.
- mem_write is never high outside WR; mem_addr/mem_wdata values outside WR are don't-care to the memory but follow the rules above.
- length, src_addr, dst_addr changing during busy have no effect.

Decomposition:
- Shared package mem_pkg: AW=16, DW=32 constants; state encoding for IDLE/RD/RDW/WR/FIN.
- One sub-module is natural: mem_copy_dp (pointer registers, remaining counter, data capture, checksum XOR), controlled by the FSM in the top. Bench instantiates mem_copy_dma with Mem_D32b_A16b.

Test Plan:
- Preload mem[5]=32'hACED_CAFE, mem[6]=32'hDEAD_BEEF; start src=5 dst=100 len=2 -> mem[100]=ACEDCAFE, mem[101]=DEADBEEF, done exactly 7 cycles after start accepted, checksum=32'h7240_7411, exactly 2 write cycles.
- len=0, src=3, dst=4 -> no mem_write ever high, done one cycle after start, checksum=0, mem[4] unchanged.
- Wrap: src=16'hFFFF len=2 (mem[FFFF]=1, mem[0]=2), dst=16'h0010 -> mem[10]=1, mem[11]=2, checksum=3.
- start pulsed again while busy with different src -> ignored; only original block copied, a single done pulse.
- rst_n low during the 2nd WR of a 4-word copy -> mem_write/busy drop immediately, no done; after release, a new start of len=1 completes normally.
- Overlap src=20 dst=21 len=3 with mem[20..22]=A,B,C -> mem[21..23]=A,A,A, checksum=A.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths and FSM state encoding for the mem_copy_dma block.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int C_AW = 16;
  localparam int C_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_copy_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_dma_if
// Brief    : Single-port memory bus between the copy engine and the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_copy_dma_if
  import mem_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
);

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_write,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_copy_dp.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_dp
// Brief    : Copy datapath: pointers, remaining count, read capture, checksum.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_dp
  import mem_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic          capture,
  input  logic          step,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] src_ptr,
  output logic [AW-1:0] dst_ptr,
  output logic [AW-1:0] remaining,
  output logic [DW-1:0] data,
  output logic [DW-1:0] checksum
);

  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [AW-1:0] r_remaining;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_checksum;

  // load and step are mutually exclusive: they come from IDLE and WR respectively
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_checksum  <= '0;
    end else begin
      if (load) begin
        r_src_ptr   <= src_addr;
        r_dst_ptr   <= dst_addr;
        r_remaining <= length;
        r_checksum  <= '0;
      end
      if (capture) begin
        r_data <= rdata;
      end
      if (step) begin
        r_checksum  <= r_checksum ^ r_data;
        r_src_ptr   <= r_src_ptr + AW'(1);
        r_dst_ptr   <= r_dst_ptr + AW'(1);
        r_remaining <= r_remaining - AW'(1);
      end
    end
  end

  assign src_ptr   = r_src_ptr;
  assign dst_ptr   = r_dst_ptr;
  assign remaining = r_remaining;
  assign data      = r_data;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_dma
// Brief    : Block copy engine for a single-port 32b/16b memory, 3 cycles/word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  mem_copy_dma_if.master mem
);

  state_t        r_state;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_write;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic          w_capture;
  logic          w_step;
  logic [AW-1:0] w_src_ptr;
  logic [AW-1:0] w_dst_ptr;
  logic [AW-1:0] w_remaining;
  logic [DW-1:0] w_data;
  logic [DW-1:0] w_checksum;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_capture = (r_state == ST_RDW);
  assign w_step    = (r_state == ST_WR);

  mem_copy_dp #(
    .AW (AW),
    .DW (DW)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .capture   (w_capture),
    .step      (w_step),
    .rdata     (mem.mem_rdata),
    .src_ptr   (w_src_ptr),
    .dst_ptr   (w_dst_ptr),
    .remaining (w_remaining),
    .data      (w_data),
    .checksum  (w_checksum)
  );

  // Outputs are assigned for the state being entered so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_mem_write <= 1'b0;
          if (start) begin
            r_busy     <= 1'b1;
            r_mem_addr <= src_addr;
            if (length == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_state <= ST_RDW;
        end
        ST_RDW: begin
          r_state     <= ST_WR;
          r_mem_addr  <= w_dst_ptr;
          r_mem_write <= 1'b1;
        end
        ST_WR: begin
          r_mem_write <= 1'b0;
          if (w_remaining == AW'(1)) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ST_RD;
            r_mem_addr <= w_src_ptr + AW'(1);
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_write <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign checksum      = w_checksum;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = w_data;
  assign mem.mem_write = r_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_dma
// Brief    : Self-checking bench for mem_copy_dma with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  mem_copy_dma_if bus ();

  mem_copy_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .mem      (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural Mem_D32b_A16b: combinational read, write on rising edge
  logic [31:0] mem     [0:65535];
  logic [31:0] exp_mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_we)    mem[pl_addr]      <= pl_data;
  end

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [47:0] sb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write scoreboard: every observed write must match the next expected one
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.mem_write) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [47:0] e;
        e = sb_q.pop_front();
        chk("sb_addr", {16'h0, bus.mem_addr}, {16'h0, e[47:32]});
        chk("sb_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    exp_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp_chk;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    int cnt;
    logic ok;
    int wr0;
    int dc0;
    logic [31:0] w;
    logic [15:0] a;
    poke(v.src, v.d0);
    poke(v.src + 16'd1, v.d1);
    poke(v.src + 16'd2, v.d2);
    poke(v.dst + v.len, 32'h5A5A_0000 | {16'h0, v.dst});
    for (int i = 0; i < int'(v.len); i++) begin
      w = exp_mem[v.src + 16'(i)];
      a = v.dst + 16'(i);
      exp_mem[a] = w;
      sb_q.push_back({a, w});
    end
    wr0 = wr_cnt;
    dc0 = done_cnt;
    @(negedge clk);
    src_addr = v.src;
    dst_addr = v.dst;
    length   = v.len;
    start    = 1'b1;
    cnt = 0;
    ok  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'h0, ok}, 32'h1);
    chk("latency", cnt, 3 * int'(v.len) + 1);
    chk("checksum", checksum, v.exp_chk);
    @(negedge clk);
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("done_pulse_1cyc", {31'h0, done}, 32'h0);
    chk("write_count", wr_cnt - wr0, int'(v.len));
    chk("done_count", done_cnt - dc0, 1);
    chk("sb_drained", sb_q.size(), 0);
    for (int i = 0; i <= int'(v.len); i++) begin
      chk("mem_dst", mem[v.dst + 16'(i)], exp_mem[v.dst + 16'(i)]);
    end
  endtask

  vec_t vecs [5];

  initial begin
    int cnt;
    logic ok;
    int wr0;
    int dc0;

    vecs[0] = '{16'd5,      16'd100,    16'd2, 32'hACED_CAFE, 32'hDEAD_BEEF, 32'h0,        32'h7240_7411};
    vecs[1] = '{16'd3,      16'd4,      16'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0};
    vecs[2] = '{16'hFFFF,   16'h0010,   16'd2, 32'h1,         32'h2,         32'h0,        32'h3};
    vecs[3] = '{16'd20,     16'd21,     16'd3, 32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000A};
    vecs[4] = '{16'd200,    16'd300,    16'd3, 32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 32'h7777_7777};

    #17;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // start pulsed while busy with another source must be ignored
    for (int i = 0; i < 4; i++) poke(16'd40 + 16'(i), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) poke(16'd60 + 16'(i), 32'hBAD0_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      exp_mem[16'd400 + 16'(i)] = 32'hC0DE_0000 + 32'(i);
      sb_q.push_back({16'd400 + 16'(i), 32'hC0DE_0000 + 32'(i)});
    end
    wr0 = wr_cnt;
    dc0 = done_cnt;
    @(negedge clk);
    src_addr = 16'd40; dst_addr = 16'd400; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    src_addr = 16'd60; dst_addr = 16'd800; length = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("busy_ign_done_seen", {31'h0, ok}, 32'h1);
    repeat (10) @(negedge clk);
    chk("busy_ign_done_count", done_cnt - dc0, 1);
    chk("busy_ign_writes", wr_cnt - wr0, 4);
    chk("busy_ign_checksum", checksum, 32'hC0DE_0000 ^ 32'hC0DE_0001 ^ 32'hC0DE_0002 ^ 32'hC0DE_0003);
    chk("busy_ign_sb", sb_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("busy_ign_mem", mem[16'd400 + 16'(i)], exp_mem[16'd400 + 16'(i)]);

    // asynchronous reset during the second write of a 4-word copy
    for (int i = 0; i < 4; i++) poke(16'd80 + 16'(i), 32'hFACE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) poke(16'd500 + 16'(i), 32'h0BAD_0000 + 32'(i));
    sb_q.push_back({16'd500, 32'hFACE_0000});
    sb_q.push_back({16'd501, 32'hFACE_0001});
    @(negedge clk);
    src_addr = 16'd80; dst_addr = 16'd500; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_write) cnt++;
      if (cnt == 2) break;
      @(negedge clk);
    end
    chk("rst_mid_reached_wr2", cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_checksum", checksum, 32'h0);
    dc0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - dc0, 0);
    chk("rst_mid_sb", sb_q.size(), 0);
    chk("rst_mid_mem500", mem[16'd500], 32'hFACE_0000);
    chk("rst_mid_mem501", mem[16'd501], 32'h0BAD_0001);
    chk("rst_mid_mem502", mem[16'd502], 32'h0BAD_0002);
    exp_mem[16'd500] = 32'hFACE_0000;

    run_xfer('{16'd600, 16'd700, 16'd1, 32'h5EED_1234, 32'h0, 32'h0, 32'h5EED_1234});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
